// File: rtl/bid_req_arbiter.sv
// Bid request arbiter: one pending slot per bidder (X/Y/Z), round-robin grant toward the core, ack/err back.
// Define BID_ARB_RETRACT_PRIO_EN to grant pending retracts ahead of pending bids.
module bid_req_arbiter #(
  parameter int AMT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              round_active,
  input  logic              X_bid,
  input  logic              Y_bid,
  input  logic              Z_bid,
  input  logic              X_retract,
  input  logic              Y_retract,
  input  logic              Z_retract,
  input  logic [AMT_W-1:0]  X_bidAmt,
  input  logic [AMT_W-1:0]  Y_bidAmt,
  input  logic [AMT_W-1:0]  Z_bidAmt,
  output logic              X_ack,
  output logic              Y_ack,
  output logic              Z_ack,
  output logic [1:0]        X_err,
  output logic [1:0]        Y_err,
  output logic [1:0]        Z_err,
  output logic              g_valid,
  input  logic              g_ready,
  output logic [1:0]        g_id,
  output logic [AMT_W-1:0]  g_amt,
  output logic              g_retract,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, OFFER, FLUSH} state_t;
  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_INACTIVE = 2'b01,
    ERR_FLUSH    = 2'b10,
    ERR_CONFLICT = 2'b11
  } err_t;

  state_t            state, state_nxt;
  logic [2:0]        bid, retract;
  logic [AMT_W-1:0]  amt_in   [3];
  logic [AMT_W-1:0]  slot_amt [3];
  logic [2:0]        occ, kind;
  logic [1:0]        rr_ptr;
  logic [2:0]        pick;
  logic              g_hs, load_offer;
  logic [2:0]        grant_clr, flush_clr, capture, drop, ack_nxt, ack_q;
  err_t              err_nxt [3];
  err_t              err_q   [3];
  logic [DROP_W:0]   drop_inc, drop_sum;

  assign bid       = {Z_bid, Y_bid, X_bid};
  assign retract   = {Z_retract, Y_retract, X_retract};
  assign amt_in[0] = X_bidAmt;
  assign amt_in[1] = Y_bidAmt;
  assign amt_in[2] = Z_bidAmt;

  // Returns {found, id}: first requester at or after ptr, wrapping X->Y->Z->X.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    idx = ptr;
    for (int k = 0; k < 3; k++) begin
      if (!res[2] && req[idx]) res = {1'b1, idx};
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return res;
  endfunction

`ifdef BID_ARB_RETRACT_PRIO_EN
  logic [2:0] pick_r, pick_b;
  assign pick_r = rr_pick(occ & kind, rr_ptr);
  assign pick_b = rr_pick(occ & ~kind, rr_ptr);
  assign pick   = pick_r[2] ? pick_r : pick_b;
`else
  assign pick = rr_pick(occ, rr_ptr);
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a falling round pre-empts any pending offer.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (!round_active) state_nxt = FLUSH;
               else if (pick[2])  state_nxt = OFFER;
      OFFER:   if (!round_active) state_nxt = FLUSH;
               else if (g_ready)  state_nxt = IDLE;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    g_valid = (state == OFFER);
  end

  assign g_hs       = g_valid && g_ready;
  assign load_offer = (state == IDLE) && (state_nxt == OFFER);
  assign grant_clr  = g_hs ? (3'b001 << g_id) : 3'b000;
  assign flush_clr  = (state == FLUSH) ? occ : 3'b000;

  // Per-bidder events. An occupied slot (through its handshake cycle) swallows strobes,
  // so a bidder can never see two acks in one cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      capture[i] = 1'b0;
      drop[i]    = 1'b0;
      ack_nxt[i] = 1'b0;
      err_nxt[i] = ERR_OK;
      if (occ[i]) begin
        drop[i] = bid[i] | retract[i];
        if (grant_clr[i]) begin
          ack_nxt[i] = 1'b1;
        end else if (flush_clr[i]) begin
          ack_nxt[i] = 1'b1;
          err_nxt[i] = ERR_FLUSH;
        end
      end else if (bid[i] || retract[i]) begin
        if (!round_active) begin
          ack_nxt[i] = 1'b1;
          err_nxt[i] = ERR_INACTIVE;
        end else if (bid[i] && retract[i]) begin
          ack_nxt[i] = 1'b1;
          err_nxt[i] = ERR_CONFLICT;
        end else begin
          capture[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    drop_inc      = '0;
    drop_inc[1:0] = {1'b0, drop[0]} + {1'b0, drop[1]} + {1'b0, drop[2]};
    drop_sum      = {1'b0, drop_cnt} + drop_inc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ       <= 3'b000;
      ack_q     <= 3'b000;
      rr_ptr    <= 2'd0;
      drop_cnt  <= '0;
      g_id      <= 2'd0;
      g_amt     <= '0;
      g_retract <= 1'b0;
      for (int i = 0; i < 3; i++) err_q[i] <= ERR_OK;
    end else begin
      occ   <= (occ & ~grant_clr & ~flush_clr) | capture;
      ack_q <= ack_nxt;
      for (int i = 0; i < 3; i++) err_q[i] <= err_nxt[i];
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      if (g_hs) rr_ptr <= (g_id == 2'd2) ? 2'd0 : g_id + 2'd1;
      if (load_offer) begin
        g_id      <= pick[1:0];
        g_amt     <= slot_amt[pick[1:0]];
        g_retract <= kind[pick[1:0]];
      end
    end
  end

  // Slot payload is only read while occ marks it valid.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; occupancy alone defines slot validity.
    for (int i = 0; i < 3; i++) begin
      if (capture[i]) begin
        kind[i]     <= retract[i];
        slot_amt[i] <= retract[i] ? '0 : amt_in[i];
      end
    end
  end

  assign X_ack = ack_q[0];
  assign Y_ack = ack_q[1];
  assign Z_ack = ack_q[2];
  assign X_err = err_q[0];
  assign Y_err = err_q[1];
  assign Z_err = err_q[2];

endmodule

// File: tb/tb_bid_req_arbiter.sv
// Directed self-checking bench for bid_req_arbiter; expectations are hand-derived cycle by cycle.
module tb_bid_req_arbiter;
  localparam int AMT_W  = 16;
  localparam int DROP_W = 8;

  logic              clk = 1'b0;
  logic              reset_n, round_active, g_ready;
  logic              x_bid, y_bid, z_bid, x_retract, y_retract, z_retract;
  logic [AMT_W-1:0]  x_amt, y_amt, z_amt;
  logic              x_ack, y_ack, z_ack;
  logic [1:0]        x_err, y_err, z_err;
  logic              g_valid, g_retract;
  logic [1:0]        g_id;
  logic [AMT_W-1:0]  g_amt;
  logic [DROP_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;
`ifdef BID_ARB_RETRACT_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  always #5 clk = ~clk;

  bid_req_arbiter #(.AMT_W(AMT_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset_n(reset_n), .round_active(round_active),
    .X_bid(x_bid), .Y_bid(y_bid), .Z_bid(z_bid),
    .X_retract(x_retract), .Y_retract(y_retract), .Z_retract(z_retract),
    .X_bidAmt(x_amt), .Y_bidAmt(y_amt), .Z_bidAmt(z_amt),
    .X_ack(x_ack), .Y_ack(y_ack), .Z_ack(z_ack),
    .X_err(x_err), .Y_err(y_err), .Z_err(z_err),
    .g_valid(g_valid), .g_ready(g_ready), .g_id(g_id), .g_amt(g_amt),
    .g_retract(g_retract), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    x_bid = 0; y_bid = 0; z_bid = 0;
    x_retract = 0; y_retract = 0; z_retract = 0;
  endtask

  task automatic do_reset();
    reset_n = 0; round_active = 0; g_ready = 0;
    clear_strobes();
    x_amt = '0; y_amt = '0; z_amt = '0;
    step();
    step();
    reset_n = 1; round_active = 1; g_ready = 1;
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_g_valid", g_valid, 0);
    check("rst_g_id", g_id, 0);
    check("rst_g_amt", g_amt, 0);
    check("rst_g_retract", g_retract, 0);
    check("rst_acks", {x_ack, y_ack, z_ack}, 0);
    check("rst_errs", {x_err, y_err, z_err}, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    // Single X bid: offer two cycles after the strobe, ack the cycle after handshake
    x_bid = 1; x_amt = 16'h0040;
    step(); clear_strobes();
    check("t1_c1_g_valid", g_valid, 0);
    step();
    check("t1_c2_g_valid", g_valid, 1);
    check("t1_c2_g_id", g_id, 0);
    check("t1_c2_g_amt", g_amt, 16'h0040);
    check("t1_c2_g_retract", g_retract, 0);
    check("t1_c2_x_ack", x_ack, 0);
    step();
    check("t1_c3_x_ack", x_ack, 1);
    check("t1_c3_x_err", x_err, 2'b00);
    check("t1_c3_g_valid", g_valid, 0);
    step();
    check("t1_c4_x_ack", x_ack, 0);

    // X,Y,Z together from rr_ptr=X: grants X,Y,Z two cycles apart
    do_reset();
    x_bid = 1; y_bid = 1; z_bid = 1;
    x_amt = 16'h0001; y_amt = 16'h0002; z_amt = 16'h0003;
    step(); clear_strobes();
    step();
    check("t2_gx_valid", g_valid, 1);
    check("t2_gx_id", g_id, 0);
    check("t2_gx_amt", g_amt, 16'h0001);
    step();
    check("t2_x_ack", x_ack, 1);
    check("t2_gap_valid", g_valid, 0);
    step();
    check("t2_gy_id", g_id, 1);
    check("t2_gy_amt", g_amt, 16'h0002);
    step();
    check("t2_y_ack", y_ack, 1);
    step();
    check("t2_gz_id", g_id, 2);
    check("t2_gz_amt", g_amt, 16'h0003);
    step();
    check("t2_z_ack", z_ack, 1);
    // rr_ptr wrapped to X: lone Z,X pair grants X first
    z_bid = 1; x_bid = 1; z_amt = 16'h0033; x_amt = 16'h0011;
    step(); clear_strobes();
    step();
    check("t2b_first_id", g_id, 0);
    check("t2b_first_amt", g_amt, 16'h0011);
    step();
    check("t2b_x_ack", x_ack, 1);
    step();
    check("t2b_second_id", g_id, 2);
    check("t2b_second_amt", g_amt, 16'h0033);
    step();
    check("t2b_z_ack", z_ack, 1);

    // g_ready low during OFFER: g_* held, no ack
    g_ready = 0;
    y_bid = 1; y_amt = 16'h1234;
    step(); clear_strobes();
    step();
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", g_valid, 1);
      check("t3_hold_id", g_id, 1);
      check("t3_hold_amt", g_amt, 16'h1234);
      check("t3_hold_no_ack", y_ack, 0);
      step();
    end
    // Y strobes while Y pending are dropped; counter saturates
    for (int i = 1; i <= 300; i++) begin
      y_bid = 1; y_amt = 16'hBEEF;
      step();
      if (i == 1)   check("t4_drop_1", drop_cnt, 8'h01);
      if (i == 254) check("t4_drop_254", drop_cnt, 8'hFE);
      if (i == 255) check("t4_drop_255", drop_cnt, 8'hFF);
      if (i == 300) check("t4_drop_300", drop_cnt, 8'hFF);
    end
    clear_strobes();
    check("t4_amt_kept", g_amt, 16'h1234);
    check("t4_no_ack_yet", y_ack, 0);
    g_ready = 1;
    step();
    check("t4_y_ack", y_ack, 1);
    check("t4_y_err", y_err, 2'b00);
    step();
    check("t4_single_ack", y_ack, 0);
    check("t4_drop_final", drop_cnt, 8'hFF);

    // Y,Z pending, round ends: both flushed in the same cycle
    g_ready = 0;
    y_bid = 1; z_bid = 1; y_amt = 16'h0005; z_amt = 16'h0006;
    step(); clear_strobes();
    step();
    check("t5_offer_valid", g_valid, 1);
    check("t5_offer_id", g_id, 2);
    round_active = 0;
    step();
    check("t5_flush_valid", g_valid, 0);
    check("t5_flush_no_ack", {y_ack, z_ack}, 2'b00);
    step();
    check("t5_flush_acks", {y_ack, z_ack}, 2'b11);
    check("t5_flush_errs", {y_err, z_err}, 4'b1010);
    z_bid = 1;
    step(); clear_strobes();
    check("t5_inactive_ack", z_ack, 1);
    check("t5_inactive_err", z_err, 2'b01);
    check("t5_inactive_y", y_ack, 0);
    step();
    check("t5_inactive_once", z_ack, 0);

    // Bid + retract same cycle: conflict, slot not loaded
    round_active = 1; g_ready = 1;
    x_bid = 1; x_retract = 1; x_amt = 16'h0099;
    step(); clear_strobes();
    check("t6_conf_ack", x_ack, 1);
    check("t6_conf_err", x_err, 2'b11);
    step();
    step();
    check("t6_no_offer", g_valid, 0);
    check("t6_no_ack", x_ack, 0);

    // X bid + Y retract from rr_ptr=X
    do_reset();
    x_bid = 1; x_amt = 16'h0055;
    y_retract = 1; y_amt = 16'h0077;
    step(); clear_strobes();
    step();
    check("t7_first_id", g_id, PRIO ? 2'd1 : 2'd0);
    check("t7_first_ret", g_retract, PRIO ? 1'b1 : 1'b0);
    check("t7_first_amt", g_amt, PRIO ? 16'h0000 : 16'h0055);
    step();
    check("t7_first_ack", {x_ack, y_ack}, PRIO ? 2'b01 : 2'b10);
    step();
    check("t7_second_id", g_id, PRIO ? 2'd0 : 2'd1);
    check("t7_second_ret", g_retract, PRIO ? 1'b0 : 1'b1);
    check("t7_second_amt", g_amt, PRIO ? 16'h0055 : 16'h0000);
    step();
    check("t7_second_ack", {x_ack, y_ack}, PRIO ? 2'b10 : 2'b01);

    // Handshake in the cycle the round ends is honoured; the rest is flushed
    do_reset();
    x_bid = 1; y_bid = 1; x_amt = 16'h0007; y_amt = 16'h0008;
    step(); clear_strobes();
    step();
    check("t8_offer_id", g_id, 0);
    round_active = 0; g_ready = 1;
    step();
    check("t8_x_ack", x_ack, 1);
    check("t8_x_err", x_err, 2'b00);
    check("t8_y_wait", y_ack, 0);
    step();
    check("t8_y_ack", y_ack, 1);
    check("t8_y_err", y_err, 2'b10);
    check("t8_x_once", x_ack, 0);

    // Reset mid-offer: offer abandoned, no ack
    do_reset();
    g_ready = 0;
    x_bid = 1; x_amt = 16'h0009;
    step(); clear_strobes();
    step();
    check("t9_offer_valid", g_valid, 1);
    reset_n = 0; g_ready = 1;
    step();
    check("t9_rst_valid", g_valid, 0);
    check("t9_rst_amt", g_amt, 0);
    check("t9_rst_ack", x_ack, 0);
    reset_n = 1;
    step();
    step();
    check("t9_after_valid", g_valid, 0);
    check("t9_after_ack", x_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
